// File: rtl/key_conditioner.sv
// key_conditioner: turns two raw active-low pushbuttons into synchronized,
// debounced press levels and single-cycle press pulses (bit 0 = left, bit 1 = right).
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic L,
  output logic R,
  output logic l_held,
  output logic r_held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] s1_q, s2_q, db_q, db_d, dly_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  // the count only advances while s2 disagrees with the debounced level
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      db_d[i]  = (s2_q[i] != db_q[i] && cnt_q[i] == LAST) ? s2_q[i] : db_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      dly_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= ~{key_r_n, key_l_n};
      s2_q     <= s1_q;
      db_q     <= db_d;
      dly_q    <= db_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end
  assign L      = db_q[0] & ~dly_q[0] & enable;
  assign R      = db_q[1] & ~dly_q[1] & enable;
  assign l_held = db_q[0];
  assign r_held = db_q[1];
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios checked cycle by cycle against a
// sliding-window debounce model through a scoreboard, plus pulse timing checks.
module tb_key_conditioner;
  localparam int N = 4;
  logic clk = 1'b0, reset, key_l_n, key_r_n, enable;
  logic L, R, l_held, r_held;
  int n_chk = 0, n_fail = 0, cyc = 0, base = 0;
  int lcnt, rcnt, l_edge, r_edge, lh1, lh0, rh1;
  logic [1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_dly = '0;
  logic [1:0] hist [$];
  logic [3:0] sb [$];

  key_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .key_l_n(key_l_n), .key_r_n(key_r_n),
    .enable(enable), .L(L), .R(R), .l_held(l_held), .r_held(r_held)
  );

  always #5 clk = ~clk;

  // db flips once the last N pre-edge s2 samples all disagree with it
  task automatic model_edge(input logic kl, input logic kr, input logic rst);
    logic [1:0] nd;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dly = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > N) void'(hist.pop_front());
      nd = m_db;
      for (int ch = 0; ch < 2; ch++) begin
        bit all_diff = (hist.size() == N);
        foreach (hist[k]) if (hist[k][ch] == m_db[ch]) all_diff = 0;
        if (all_diff) nd[ch] = ~m_db[ch];
      end
      m_dly = m_db;
      m_db  = nd;
      m_s2  = m_s1;
      m_s1  = ~{kr, kl};
    end
  endtask

  task automatic step(input logic kl, input logic kr, input logic en, input logic rst);
    logic [3:0] e, o;
    key_l_n = kl; key_r_n = kr; enable = en; reset = rst;
    model_edge(kl, kr, rst);
    sb.push_back({m_db[1] & ~m_dly[1] & en, m_db[0] & ~m_dly[0] & en, m_db[1], m_db[0]});
    @(posedge clk);
    #1;
    cyc++;
    o = {R, L, r_held, l_held};
    e = sb.pop_front();
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL step cyc=%0d observed {R,L,rh,lh}=%b expected=%b", cyc, o, e);
    end
    if (L) begin lcnt++; l_edge = cyc - base; end
    if (R) begin rcnt++; r_edge = cyc - base; end
    if (l_held && lh1 == 0) lh1 = cyc - base;
    if (!l_held && lh0 == 0) lh0 = cyc - base;
    if (r_held && rh1 == 0) rh1 = cyc - base;
  endtask

  task automatic mark();
    base = cyc; lcnt = 0; rcnt = 0; l_edge = 0; r_edge = 0; lh1 = 0; lh0 = 0; rh1 = 0;
  endtask

  task automatic chk(input string tag, input int o, input int e);
    n_chk++;
    assert (o == e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  initial begin
    key_l_n = 1; key_r_n = 1; enable = 1; reset = 1;
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    chk("reset_outputs", int'({L, R, l_held, r_held}), 0);
    // single left press
    mark();
    repeat (20) step(0, 1, 1, 0);
    chk("press_l_count", lcnt, 1);
    chk("press_l_edge", l_edge, N + 2);
    chk("press_l_held_edge", lh1, N + 2);
    chk("press_r_quiet", rcnt + rh1, 0);
    // release left
    mark();
    repeat (10) step(1, 1, 1, 0);
    chk("release_l_count", lcnt, 0);
    chk("release_l_fall_edge", lh0, N + 2);
    // bounce on right: 3 low, 1 high, then held
    mark();
    repeat (3) step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    repeat (12) step(1, 0, 1, 0);
    chk("bounce_r_count", rcnt, 1);
    chk("bounce_r_edge", r_edge, 4 + N + 2);
    chk("bounce_r_held_edge", rh1, 4 + N + 2);
    repeat (10) step(1, 1, 1, 0);
    // simultaneous presses
    mark();
    repeat (12) step(0, 0, 1, 0);
    chk("simul_l_count", lcnt, 1);
    chk("simul_r_count", rcnt, 1);
    chk("simul_l_edge", l_edge, N + 2);
    chk("simul_r_edge", r_edge, N + 2);
    chk("simul_held", int'({l_held, r_held}), 3);
    repeat (10) step(1, 1, 1, 0);
    // enable mask
    mark();
    repeat (12) step(0, 1, 0, 0);
    chk("mask_l_held", int'(l_held), 1);
    repeat (5) step(0, 1, 1, 0);
    chk("mask_l_count", lcnt, 0);
    repeat (10) step(1, 1, 1, 0);
    mark();
    repeat (12) step(0, 1, 1, 0);
    chk("unmask_l_count", lcnt, 1);
    chk("unmask_l_edge", l_edge, N + 2);
    repeat (10) step(1, 1, 1, 0);
    // reset mid-debounce with key held
    mark();
    repeat (3) step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    chk("midrst_l_held", int'(l_held), 0);
    chk("midrst_no_early_pulse", lcnt, 0);
    repeat (15) step(0, 1, 1, 0);
    chk("midrst_l_count", lcnt, 1);
    chk("midrst_l_edge", l_edge, 4 + N + 2);
    repeat (10) step(1, 1, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Upstream input stage for the tug-of-war playfield. Converts the two raw player pushbuttons into clean single-cycle press pulses.
- The L and R pulses feed every playfield light cell, including the center light and the edge lights.
- Each channel has a 2-flop synchronizer, a stable-count debouncer and a rising-edge pulse generator.
- An enable input masks pulses once the game is decided.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles the key must hold a new level before the debounced level changes. Legal range 1..65535. Counter width is $clog2(DEBOUNCE_CYCLES)+1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key_l_n  input  1  raw left pushbutton, asynchronous, active-low (0 = pressed)
- key_r_n  input  1  raw right pushbutton, asynchronous, active-low
- enable  input  1  1 = pulses allowed; 0 = pulses masked (game over)
- L  output  1  one-cycle pulse per debounced left press
- R  output  1  one-cycle pulse per debounced right press
- l_held  output  1  debounced left level, 1 = pressed
- r_held  output  1  debounced right level, 1 = pressed

Behaviour:
- Two identical, fully independent channels. There is no arbitration between them.
- Per-channel state:
  - s1, s2: synchronizer flops, inverted so 1 = pressed.
  - cnt: debounce counter.
  - db: debounced level, drives *_held.
  - db_d: db delayed one cycle.
- Reset (synchronous, active-high):
  - s1 = s2 = 0, cnt = 0, db = 0, db_d = 0.
  - L = R = 0, l_held = r_held = 0.
  - Reset asserted mid-debounce discards the count.
- Synchronizer:
  - s1 <= ~key_n; s2 <= s1.
  - Only s2 is used downstream.
- Debounce, evaluated every clock:
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency (N = DEBOUNCE_CYCLES):
  - A raw level stable from before rising edge 1 reaches s2 at edge 2.
  - db changes at edge N+2.
- Bounce rejection:
  - Any s2 excursion back to db before the count completes clears cnt.
  - Glitches shorter than N synchronized cycles never change db.
- Pulse generation:
  - db_d <= db every clock.
  - L = db_l & ~db_d_l & enable. R is the same for the right channel.
  - L/R are high for exactly one cycle, from edge N+2 to edge N+3.
  - Release (db 1->0) produces no pulse.
  - A key held indefinitely produces exactly one pulse.
- Enable:
  - Combinational mask only. Debounce and held levels keep tracking while enable = 0.
  - Raising enable while a key is held emits no pulse; the edge has already passed.
  - A press whose db edge occurs while enable = 0 is lost.
- Simultaneous presses:
  - L and R may assert in the same cycle.
  - Downstream cells treat L&R as no move; this block passes both through unchanged.
- Key held through reset:
  - After reset deasserts, the held key counts as a new press.
  - One pulse is emitted N+2 cycles after the first post-reset edge.
- Outputs are glitch-free: derived only from flops and the enable input.

Test Plan:
- Reset, N=4; key_l_n driven 1->0 just before edge 1 and held 20 cycles -> l_held rises after edge 6; L = 1 for exactly the one cycle between edges 6 and 7; L = 0 for all remaining cycles; R and r_held stay 0.
- Bounce rejection, N=4: key_r_n low for 3 cycles, high for 1, then low and held -> no change from the 3-cycle burst; r_held rises 6 edges after the final falling edge; single R pulse.
- Release: after a held left press, key_l_n returns to 1 and stays -> l_held falls 6 edges later; no L pulse on release.
- Simultaneous: both keys pressed in the same cycle -> L and R pulse together for one cycle at edge 6; both held levels are 1.
- Enable mask: enable = 0, press left -> l_held rises, L stays 0. Raise enable with the key still held -> still no pulse. Release, then press again -> one L pulse.
- Reset mid-operation: press left, assert reset at edge 4 for one cycle with the key still held -> no pulse before or during reset; L pulses exactly once, 6 edges after reset deasserts; l_held = 0 throughout reset.
